rf_pulse_seq: RTL and testbench

Parametrised, trigger-driven multi-channel pulse sequencer for MKRVIDOR4000 FPGA designs. It generalises the single-output trigger-to-RF-gate controller: a rising edge on an asynchronous MKR pin starts a sequence in which each of `CHANNELS` outputs produces one gate pulse with a programmable delay and width. An enforced hold-off follows each sequence, and an optional burst repeat is available. It instantiates in the top level with the trigger on a `bMKR_D` pin, the gates on `bMKR_D` pins, and configuration from the SAM/JTAG register bridge.

---
 rtl/rf_pulse_seq_if.sv | 20 ++
 rtl/rf_pulse_seq.sv | 223 ++++++++++++++++++++++
 tb/tb_rf_pulse_seq.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rf_pulse_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : rf_pulse_seq_if
//  Description : Configuration write bus for rf_pulse_seq.
//                Carries a one-cycle write strobe, the register address and
//                the write data.
//  Revision    : 1.0 - initial release
// ============================================================================
interface rf_pulse_seq_if #(
   parameter int ADDR_W = 4,
   parameter int CNT_W  = 16
);
   logic              iWR;
   logic [ADDR_W-1:0] iADDR;
   logic [CNT_W-1:0]  iWDATA;

   modport master (output iWR, output iADDR, output iWDATA);
   modport slave  (input  iWR, input  iADDR, input  iWDATA);
endinterface
`default_nettype wire

// File: rtl/rf_pulse_seq.sv
`default_nettype none
// ============================================================================
//  Module      : rf_pulse_seq
//  Description : Trigger-driven multi-channel RF gate pulse sequencer.
//                A synchronised rising edge on iTRIG starts a run in which
//                each channel emits one gate pulse of programmable delay and
//                width, followed by an enforced hold-off.
//                Optional feature macro: RF_SEQ_BURST_EN (burst repeat).
//  Revision    : 1.0 - initial release
// ============================================================================
module rf_pulse_seq #(
   parameter int CHANNELS = 4,
   parameter int CNT_W    = 16,
   parameter int ADDR_W   = 4
) (
   input  logic                iCLK,
   input  logic                iRESETn,
   input  logic                iTRIG,
   rf_pulse_seq_if.slave       cfg_i,
   output logic [CHANNELS-1:0] oRF,
   output logic                oBUSY,
   output logic                oDONE,
   output logic                oOVERRUN
);
   // Run timer is one bit wider so DELAY+WIDTH never wraps.
   localparam int TW = CNT_W + 1;

   localparam logic [1:0] c_IDLE = 2'd0;
   localparam logic [1:0] c_RUN  = 2'd1;
   localparam logic [1:0] c_HOLD = 2'd2;

   logic [2:0]          sync_q;
   logic                w_edge;

   logic [CNT_W-1:0]    stg_delay_q [CHANNELS];
   logic [CNT_W-1:0]    stg_width_q [CHANNELS];
   logic [CNT_W-1:0]    stg_hold_q;
   logic [CNT_W-1:0]    act_delay_q [CHANNELS];
   logic [CNT_W-1:0]    act_width_q [CHANNELS];
   logic [CNT_W-1:0]    act_hold_q;

   logic [1:0]          state_q, state_d;
   logic [TW-1:0]       t_q, t_d;
   logic [CNT_W-1:0]    h_q, h_d;

   logic [TW-1:0]       w_end [CHANNELS];
   logic [TW-1:0]       w_len;
   logic                w_run_last;
   logic                w_hold_last;
   logic                w_repeat;

   logic [CHANNELS-1:0] rf_q, rf_d;
   logic                done_q, done_d;
   logic                ovr_q, ovr_d;

`ifdef RF_SEQ_BURST_EN
   logic [CNT_W-1:0]    stg_burst_q;
   logic [CNT_W-1:0]    act_burst_q;
   logic [CNT_W-1:0]    rep_q, rep_d;

   // Another pass is due while rep+1 is below max(BURST,1).
   assign w_repeat = (TW'(rep_q) + TW'(1)) <
                     ((act_burst_q == '0) ? TW'(1) : TW'(act_burst_q));
`else
   assign w_repeat = 1'b0;
`endif

   // Two-flop synchroniser plus one history flop for edge detection.
   always_ff @(posedge iCLK) begin
      if (!iRESETn) sync_q <= '0;
      else          sync_q <= {sync_q[1:0], iTRIG};
   end

   assign w_edge = sync_q[1] & ~sync_q[2];

   // Staging registers written from the configuration bus.
   always_ff @(posedge iCLK) begin
      if (!iRESETn) begin
         for (int i = 0; i < CHANNELS; i++) begin
            stg_delay_q[i] <= '0;
            stg_width_q[i] <= '0;
         end
         stg_hold_q <= '0;
`ifdef RF_SEQ_BURST_EN
         stg_burst_q <= '0;
`endif
      end else if (cfg_i.iWR) begin
         for (int i = 0; i < CHANNELS; i++) begin
            if (cfg_i.iADDR == ADDR_W'(2 * i))     stg_delay_q[i] <= cfg_i.iWDATA;
            if (cfg_i.iADDR == ADDR_W'(2 * i + 1)) stg_width_q[i] <= cfg_i.iWDATA;
         end
         if (cfg_i.iADDR == ADDR_W'(2 * CHANNELS)) stg_hold_q <= cfg_i.iWDATA;
`ifdef RF_SEQ_BURST_EN
         if (cfg_i.iADDR == ADDR_W'(2 * CHANNELS + 1)) stg_burst_q <= cfg_i.iWDATA;
`endif
      end
   end

   // Snapshot staging into the active copy when a trigger is accepted.
   always_ff @(posedge iCLK) begin
      if (!iRESETn) begin
         for (int i = 0; i < CHANNELS; i++) begin
            act_delay_q[i] <= '0;
            act_width_q[i] <= '0;
         end
         act_hold_q <= '0;
`ifdef RF_SEQ_BURST_EN
         act_burst_q <= '0;
`endif
      end else if (state_q == c_IDLE && w_edge) begin
         act_delay_q <= stg_delay_q;
         act_width_q <= stg_width_q;
         act_hold_q  <= stg_hold_q;
`ifdef RF_SEQ_BURST_EN
         act_burst_q <= stg_burst_q;
`endif
      end
   end

   // Per-channel end times and the overall run length.
   always_comb begin
      w_len = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         w_end[i] = TW'(act_delay_q[i]) + TW'(act_width_q[i]);
         if (w_end[i] > w_len) w_len = w_end[i];
      end
      w_run_last  = (w_len == '0) || (t_q == w_len - TW'(1));
      w_hold_last = (act_hold_q == '0) || (h_q >= act_hold_q - CNT_W'(1));
   end

   // State register with run timer, hold counter and repeat counter.
   always_ff @(posedge iCLK) begin
      if (!iRESETn) begin
         state_q <= c_IDLE;
         t_q     <= '0;
         h_q     <= '0;
`ifdef RF_SEQ_BURST_EN
         rep_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         t_q     <= t_d;
         h_q     <= h_d;
`ifdef RF_SEQ_BURST_EN
         rep_q   <= rep_d;
`endif
      end
   end

   // Next-state and counter update logic.
   always_comb begin
      state_d = state_q;
      t_d     = t_q;
      h_d     = h_q;
`ifdef RF_SEQ_BURST_EN
      rep_d   = rep_q;
`endif
      case (state_q)
         c_IDLE: begin
            if (w_edge) begin
               state_d = c_RUN;
               t_d     = '0;
`ifdef RF_SEQ_BURST_EN
               rep_d   = '0;
`endif
            end
         end
         c_RUN: begin
            t_d = t_q + TW'(1);
            if (w_run_last) begin
               state_d = c_HOLD;
               h_d     = '0;
            end
         end
         c_HOLD: begin
            h_d = h_q + CNT_W'(1);
            if (w_hold_last) begin
               if (w_repeat) begin
                  state_d = c_RUN;
                  t_d     = '0;
`ifdef RF_SEQ_BURST_EN
                  rep_d   = rep_q + CNT_W'(1);
`endif
               end else begin
                  state_d = c_IDLE;
               end
            end
         end
         default: state_d = c_IDLE;
      endcase
   end

   // Output decode: gate windows, completion and overrun pulses.
   always_comb begin
      rf_d = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         rf_d[i] = (state_q == c_RUN) &&
                   (t_q >= TW'(act_delay_q[i])) && (t_q < w_end[i]);
      end
      done_d = (state_q == c_HOLD) && w_hold_last && !w_repeat;
      ovr_d  = w_edge && (state_q != c_IDLE);
   end

   // Registered outputs.
   always_ff @(posedge iCLK) begin
      if (!iRESETn) begin
         rf_q   <= '0;
         done_q <= 1'b0;
         ovr_q  <= 1'b0;
      end else begin
         rf_q   <= rf_d;
         done_q <= done_d;
         ovr_q  <= ovr_d;
      end
   end

   assign oRF      = rf_q;
   assign oBUSY    = (state_q != c_IDLE);
   assign oDONE    = done_q;
   assign oOVERRUN = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_rf_pulse_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rf_pulse_seq
//  Description : Self-checking bench for rf_pulse_seq with a timeline model
//                of each accepted sequence plus directed literal checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_pulse_seq;
   localparam int CH = 4;
   localparam int CW = 16;
   localparam int AW = 4;

   logic          iCLK    = 1'b0;
   logic          iRESETn = 1'b0;
   logic          iTRIG   = 1'b0;
   logic [CH-1:0] oRF;
   logic          oBUSY, oDONE, oOVERRUN;

   rf_pulse_seq_if #(.ADDR_W(AW), .CNT_W(CW)) cfg_bus ();

   rf_pulse_seq #(.CHANNELS(CH), .CNT_W(CW), .ADDR_W(AW)) dut (
      .iCLK     (iCLK),
      .iRESETn  (iRESETn),
      .iTRIG    (iTRIG),
      .cfg_i    (cfg_bus),
      .oRF      (oRF),
      .oBUSY    (oBUSY),
      .oDONE    (oDONE),
      .oOVERRUN (oOVERRUN)
   );

   always #5 iCLK = ~iCLK;

   int     n_checks = 0;
   int     n_errors = 0;
   bit     chk_en   = 1'b0;

   // Model: staging copy, trigger sample history, and the timeline of the
   // most recently accepted sequence (start edge, repeat count, period).
   longint cyc = 0;
   bit     m_s1, m_s2, m_s3, m_e;
   bit     m_valid, m_ovr;
   longint m_start, m_B, m_P, m_len;
   longint m_D [CH];
   longint m_W [CH];
   longint stg_d [CH];
   longint stg_w [CH];
   longint stg_h, stg_b;
   int     m_a;

   int     rf0_hi_cnt, done_cnt, ovr_cnt, busy_cnt;
   longint rf0_first;

   longint c_off, c_m;
   logic [CH-1:0] c_rf;
   logic   c_busy, c_done;

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
      end
   endtask

   always @(posedge iCLK) begin
      cyc = cyc + 1;
      if (!iRESETn) begin
         m_s1 = 0; m_s2 = 0; m_s3 = 0;
         m_valid = 0; m_ovr = 0;
         for (int i = 0; i < CH; i++) begin stg_d[i] = 0; stg_w[i] = 0; end
         stg_h = 0; stg_b = 0;
      end else begin
         m_e   = m_s2 & ~m_s3;
         m_ovr = 0;
         if (m_e) begin
            if (!m_valid || cyc >= m_start + m_B * m_P + 1) begin
               m_len = 0;
               for (int i = 0; i < CH; i++) begin
                  m_D[i] = stg_d[i];
                  m_W[i] = stg_w[i];
                  if (stg_d[i] + stg_w[i] > m_len) m_len = stg_d[i] + stg_w[i];
               end
               m_P = ((m_len == 0) ? 1 : m_len) + ((stg_h == 0) ? 1 : stg_h);
`ifdef RF_SEQ_BURST_EN
               m_B = (stg_b == 0) ? 1 : stg_b;
`else
               m_B = 1;
`endif
               m_start = cyc;
               m_valid = 1;
            end else begin
               m_ovr = 1;
            end
         end
         m_s3 = m_s2; m_s2 = m_s1; m_s1 = iTRIG;
         if (cfg_bus.iWR) begin
            m_a = int'(cfg_bus.iADDR);
            if (m_a < 2 * CH) begin
               if (m_a % 2 == 0) stg_d[m_a / 2] = longint'(cfg_bus.iWDATA);
               else              stg_w[m_a / 2] = longint'(cfg_bus.iWDATA);
            end else if (m_a == 2 * CH)     stg_h = longint'(cfg_bus.iWDATA);
            else if (m_a == 2 * CH + 1)     stg_b = longint'(cfg_bus.iWDATA);
         end
      end
   end

   // Compare DUT outputs against the model timeline every cycle.
   always @(negedge iCLK) begin
      if (chk_en) begin
         c_rf  = '0;
         c_off = cyc - m_start - 1;
         if (m_valid && c_off >= 0 && c_off < m_B * m_P) begin
            c_m = c_off % m_P;
            for (int i = 0; i < CH; i++)
               c_rf[i] = (c_m >= m_D[i]) && (c_m < m_D[i] + m_W[i]);
         end
         c_busy = m_valid && cyc >= m_start && cyc < m_start + m_B * m_P;
         c_done = m_valid && cyc == m_start + m_B * m_P;
         check("model_oRF", oRF, c_rf);
         check("model_oBUSY", oBUSY, c_busy);
         check("model_oDONE", oDONE, c_done);
         check("model_oOVERRUN", oOVERRUN, m_ovr);
      end
      if (oRF[0] === 1'b1) begin
         if (rf0_hi_cnt == 0) rf0_first = cyc;
         rf0_hi_cnt++;
      end
      if (oDONE === 1'b1)    done_cnt++;
      if (oOVERRUN === 1'b1) ovr_cnt++;
      if (oBUSY === 1'b1)    busy_cnt++;
   end

   task automatic clr_cnt();
      @(posedge iCLK); #1;
      rf0_hi_cnt = 0; done_cnt = 0; ovr_cnt = 0; busy_cnt = 0; rf0_first = -1;
   endtask

   task automatic wr(input int a, input int d);
      @(negedge iCLK);
      cfg_bus.iWR    = 1'b1;
      cfg_bus.iADDR  = a[AW-1:0];
      cfg_bus.iWDATA = d[CW-1:0];
      @(negedge iCLK);
      cfg_bus.iWR    = 1'b0;
   endtask

   task automatic clear_cfg();
      for (int a = 0; a < 2 * CH + 2; a++) wr(a, 0);
   endtask

   task automatic fire(output longint n);
      @(negedge iCLK);
      iTRIG = 1'b1;
      n = cyc + 1;
      repeat (3) @(negedge iCLK);
      iTRIG = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int k = 0;
      while (oBUSY === 1'b1 && k < budget) begin @(negedge iCLK); k++; end
      check("idle_timeout", oBUSY, 0);
      repeat (4) @(negedge iCLK);
   endtask

   task automatic wait_rf0(input logic level, input int budget);
      int k = 0;
      while (oRF[0] !== level && k < budget) begin @(negedge iCLK); k++; end
      check("wait_rf0_timeout", oRF[0], level);
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      longint n;
      cfg_bus.iWR = 1'b0; cfg_bus.iADDR = '0; cfg_bus.iWDATA = '0;
      repeat (3) @(negedge iCLK);
      chk_en = 1'b1;
      check("rst_oRF", oRF, 0);
      check("rst_oBUSY", oBUSY, 0);
      check("rst_oDONE", oDONE, 0);
      check("rst_oOVERRUN", oOVERRUN, 0);
      iRESETn = 1'b1;
      repeat (2) @(negedge iCLK);

      // Single shot, literal per-edge expectations relative to trigger edge n.
      clear_cfg();
      wr(0, 5); wr(1, 3);
      @(negedge iCLK);
      iTRIG = 1'b1;
      for (int k = 0; k <= 14; k++) begin
         @(negedge iCLK);
         if (k == 3) iTRIG = 1'b0;
         check("ss_rf0", oRF[0], (k >= 8 && k <= 10));
         check("ss_busy", oBUSY, (k >= 2 && k <= 10));
         check("ss_done", oDONE, (k == 11));
         check("ss_rf_other", oRF[3:1], 0);
      end

      // Multi-channel overlap, LEN = 11, channel 3 silent.
      clear_cfg();
      wr(0, 0); wr(1, 4); wr(2, 2); wr(3, 4); wr(4, 10); wr(5, 1);
      clr_cnt();
      fire(n);
      wait_idle(100);
      check("mc_rf0_cycles", rf0_hi_cnt, 4);
      check("mc_busy_cycles", busy_cnt, 12);
      check("mc_done_count", done_cnt, 1);

      // Hold-off overrun, then an accepted retrigger after oDONE.
      clear_cfg();
      wr(0, 2); wr(1, 3); wr(8, 20);
      clr_cnt();
      fire(n);
      wait_rf0(1'b1, 30);
      wait_rf0(1'b0, 30);
      repeat (5) @(negedge iCLK);
      fire(n);
      wait_idle(100);
      check("ho_overrun_count", ovr_cnt, 1);
      check("ho_done_count", done_cnt, 1);
      fire(n);
      wait_idle(100);
      check("ho_retrig_done", done_cnt, 2);
      check("ho_retrig_rf0", rf0_hi_cnt, 6);

      // Wide values: no wrap in DELAY + WIDTH.
      clear_cfg();
      wr(0, 'hFFFF); wr(1, 2);
      clr_cnt();
      fire(n);
      wait_idle(70000);
      check("wide_rise_offset", rf0_first - n, 3 + 65535);
      check("wide_rf0_cycles", rf0_hi_cnt, 2);
      check("wide_done_count", done_cnt, 1);

      // Reset in the middle of a run.
      clear_cfg();
      wr(0, 0); wr(1, 10); wr(8, 3);
      clr_cnt();
      fire(n);
      wait_rf0(1'b1, 20);
      iRESETn = 1'b0;
      @(negedge iCLK);
      check("mr_oRF", oRF, 0);
      check("mr_oBUSY", oBUSY, 0);
      iRESETn = 1'b1;
      repeat (3) @(negedge iCLK);
      check("mr_done_count", done_cnt, 0);
      clr_cnt();
      fire(n);
      wait_idle(50);
      check("mr_cleared_rf0", rf0_hi_cnt, 0);
      check("mr_cleared_busy", busy_cnt, 2);

      // Burst repeat.
      clear_cfg();
      wr(0, 1); wr(1, 2); wr(8, 4); wr(9, 3);
      clr_cnt();
      fire(n);
      wait_idle(200);
`ifdef RF_SEQ_BURST_EN
      check("burst_rf0_cycles", rf0_hi_cnt, 6);
      check("burst_busy_cycles", busy_cnt, 21);
`else
      check("burst_rf0_cycles", rf0_hi_cnt, 2);
      check("burst_busy_cycles", busy_cnt, 7);
`endif
      check("burst_done_count", done_cnt, 1);

      // Randomised triggers, writes (including unmapped and while busy)
      // and occasional resets, checked by the model.
      clear_cfg();
      for (int c = 0; c < 3000; c++) begin
         @(negedge iCLK);
         cfg_bus.iWR = 1'b0;
         iRESETn     = 1'b1;
         if ($urandom_range(0, 3) == 0) iTRIG = ~iTRIG;
         if ($urandom_range(0, 5) == 0) begin
            cfg_bus.iWR    = 1'b1;
            cfg_bus.iADDR  = AW'($urandom_range(0, 15));
            cfg_bus.iWDATA = CW'($urandom_range(0, 12));
         end
         if ($urandom_range(0, 499) == 0) iRESETn = 1'b0;
      end
      @(negedge iCLK);
      cfg_bus.iWR = 1'b0;
      iRESETn     = 1'b1;
      iTRIG       = 1'b0;
      wait_idle(2000);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
`default_nettype wire
